// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out word streamer.
// The pointer-width helper is reused by the serial-in collector.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Width of a word pointer that indexes 0..depth-1 (never narrower than one bit).
    function automatic int piso_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/piso_counter.sv
// Word pointer counter: synchronous reset, clear and increment enable.
// Clear has priority over increment; the owner decides when to stop counting.
module piso_counter #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] r_count;

    // Pointer register: reset and clear both return to word 0.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            r_count <= {width_p{1'b0}};
        end else if (en_i) begin
            r_count <= r_count + width_p'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/piso.sv
// Parallel-in, serial-out streamer: loads a full vector in one handshake and
// emits it word 0 first on a valid/ready stream, with one idle cycle between vectors.
module piso
    import piso_pkg::*;
#(
    parameter int width_p = 8,
    parameter int depth_p = 128
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [width_p*depth_p-1:0] data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [width_p-1:0]         data_o,
    output logic                       last_o
);

    localparam int ptr_width_lp = piso_ptr_width(depth_p);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(depth_p - 1);

    state_e                    state_r;
    logic [ptr_width_lp-1:0]   rd_ptr_r;
    logic [width_p-1:0]        buf_r [depth_p];

    logic w_load;
    logic w_fire;
    logic w_at_last;

    assign ready_o   = (state_r == IDLE) & ~reset_i;
    assign valid_o   = (state_r == SEND);
    assign w_at_last = (rd_ptr_r == last_ptr_lp);
    assign last_o    = valid_o & w_at_last;
    assign data_o    = buf_r[rd_ptr_r];
    assign w_load    = valid_i & ready_o;
    assign w_fire    = valid_o & ready_i;

    // The pointer stops at the last word and clears instead of wrapping,
    // so non-power-of-two depths never index past the buffer.
    piso_counter #(
        .width_p (ptr_width_lp)
    ) u_rd_ptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_load | (w_fire & w_at_last)),
        .en_i    (w_fire & ~w_at_last),
        .count_o (rd_ptr_r)
    );

    // Control FSM: IDLE accepts a vector, SEND drains it word by word.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (w_load) state_r <= SEND;
                    else        state_r <= IDLE;
                end
                SEND: begin
                    if (w_fire && w_at_last) state_r <= IDLE;
                    else                     state_r <= SEND;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Vector buffer: captured only on an accepted load, never cleared by reset.
    always_ff @(posedge clk_i) begin
        if (w_load) begin
            for (int k = 0; k < depth_p; k++) begin
                buf_r[k] <= data_i[k*width_p +: width_p];
            end
        end
    end

endmodule

// File: tb/tb_piso.sv
// Scoreboard bench for piso: a depth-4 and a depth-5 instance, each with a
// queue-based reference of the words it must emit.
module tb_piso;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic        rst4 = 1'b1, vin4 = 1'b0, rdy4 = 1'b1;
    logic [31:0] din4 = 32'h0;
    logic        ready4, valid4, last4;
    logic [7:0]  dout4;

    logic        rst5 = 1'b1, vin5 = 1'b0, rdy5 = 1'b1;
    logic [39:0] din5 = 40'h0;
    logic        ready5, valid5, last5;
    logic [7:0]  dout5;

    exp_t q4[$];
    exp_t q5[$];

    piso #(.width_p(8), .depth_p(4)) dut4 (
        .clk_i(clk), .reset_i(rst4), .valid_i(vin4), .ready_o(ready4), .data_i(din4),
        .valid_o(valid4), .ready_i(rdy4), .data_o(dout4), .last_o(last4)
    );

    piso #(.width_p(8), .depth_p(5)) dut5 (
        .clk_i(clk), .reset_i(rst5), .valid_i(vin5), .ready_o(ready5), .data_i(din5),
        .valid_o(valid5), .ready_i(rdy5), .data_o(dout5), .last_o(last5)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // Depth-4 scoreboard: model says busy exactly while words remain to be sent.
    always @(negedge clk) begin
        if (rst4) begin
            check1("ready4_in_reset", ready4, 1'b0);
            q4.delete();
        end else if (q4.size() != 0) begin
            check1("ready4_busy", ready4, 1'b0);
            check1("valid4_busy", valid4, 1'b1);
            check8("data4", dout4, q4[0].d);
            check1("last4", last4, q4[0].l);
            if (rdy4) void'(q4.pop_front());
        end else begin
            check1("ready4_idle", ready4, 1'b1);
            check1("valid4_idle", valid4, 1'b0);
            check1("last4_idle", last4, 1'b0);
            if (vin4) begin
                for (int k = 0; k < 4; k++) q4.push_back('{d: 8'(din4 >> (8*k)), l: (k == 3)});
            end
        end
    end

    // Depth-5 scoreboard plus the pointer bound for a non-power-of-two depth.
    always @(negedge clk) begin
        check1("ptr5_bound", dut5.rd_ptr_r <= 3'd4, 1'b1);
        if (rst5) begin
            check1("ready5_in_reset", ready5, 1'b0);
            q5.delete();
        end else if (q5.size() != 0) begin
            check1("ready5_busy", ready5, 1'b0);
            check1("valid5_busy", valid5, 1'b1);
            check8("data5", dout5, q5[0].d);
            check1("last5", last5, q5[0].l);
            if (rdy5) void'(q5.pop_front());
        end else begin
            check1("ready5_idle", ready5, 1'b1);
            check1("valid5_idle", valid5, 1'b0);
            check1("last5_idle", last5, 1'b0);
            if (vin5) begin
                for (int k = 0; k < 5; k++) q5.push_back('{d: 8'(din5 >> (8*k)), l: (k == 4)});
            end
        end
    end

    task automatic load4(input logic [31:0] v);
        @(posedge clk); #1 vin4 = 1'b1; din4 = v;
        @(posedge clk); #1 vin4 = 1'b0; din4 = $urandom;
    endtask

    task automatic load5(input logic [39:0] v);
        @(posedge clk); #1 vin5 = 1'b1; din5 = v;
        @(posedge clk); #1 vin5 = 1'b0; din5 = {8'($urandom), 32'($urandom)};
    endtask

    task automatic drain4(input bit rnd);
        int n = 0;
        while (q4.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            if (rnd) rdy4 = 1'($urandom_range(0, 1));
            n++;
        end
        if (q4.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain4_timeout: %0d words still pending after %0d cycles", q4.size(), n);
        end
        rdy4 = 1'b1;
    endtask

    task automatic drain5(input bit rnd);
        int n = 0;
        while (q5.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            if (rnd) rdy5 = 1'($urandom_range(0, 1));
            n++;
        end
        if (q5.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain5_timeout: %0d words still pending after %0d cycles", q5.size(), n);
        end
        rdy5 = 1'b1;
    endtask

    initial begin
        // Reset held for a few idle cycles, then released.
        repeat (3) @(posedge clk);
        #1 rst4 = 1'b0;
        repeat (2) @(posedge clk);

        // Basic stream.
        load4(32'h44332211);
        drain4(1'b0);

        // Backpressure while word 1 is presented.
        load4(32'h44332211);
        @(posedge clk); #1 rdy4 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy4 = 1'b1;
        drain4(1'b0);

        // Load attempt during SEND must be ignored.
        load4(32'h44332211);
        vin4 = 1'b1; din4 = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1 vin4 = 1'b0;
        drain4(1'b0);
        load4(32'h88776655);
        drain4(1'b0);

        // Reset after word 1 has been accepted abandons the vector.
        load4(32'h44332211);
        @(posedge clk);
        @(posedge clk); #1 rst4 = 1'b1;
        @(posedge clk); #1 rst4 = 1'b0;
        @(posedge clk);
        load4(32'hA3A2A1A0);
        drain4(1'b0);

        // Random vectors with random consumer stalls.
        for (int i = 0; i < 6; i++) begin
            load4($urandom);
            drain4(1'b1);
        end

        // Non-power-of-two depth.
        @(posedge clk); #1 rst5 = 1'b0;
        @(posedge clk);
        load5(40'h0504030201);
        drain5(1'b1);
        for (int i = 0; i < 4; i++) begin
            load5({8'($urandom), 32'($urandom)});
            drain5(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
